// File: rtl/slowclk_edge_monitor.sv
// Brings a slow toggling signal into the clk_in domain, emits one-cycle rise/fall ticks,
// measures the rise-to-rise period and flags a stall when the input stops toggling.
module slowclk_edge_monitor #(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      CNT_W       = 26,
  parameter logic [CNT_W-1:0] TIMEOUT     = 26'd50_000_000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             slow_in,
  output logic             slow_sync,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       pcnt;
  logic [CNT_W-1:0]       icnt;
  state_t                 state;

  logic                   rise;
  logic                   fall;
  logic                   edge_seen;
  logic                   stall_hit;
  logic [CNT_W-1:0]       pcnt_inc;
  logic [CNT_W-1:0]       icnt_next;

  assign slow_sync = sync_q[SYNC_STAGES-1];

  // An edge in the same cycle as the timeout always wins, so stalled never
  // asserts in a cycle that also carries a tick.
  always_comb begin
    rise      = slow_sync & ~prev_q;
    fall      = ~slow_sync & prev_q;
    edge_seen = rise | fall;
    stall_hit = (icnt == TIMEOUT) & ~edge_seen;
    pcnt_inc  = (pcnt == CNT_MAX) ? CNT_MAX : pcnt + 1'b1;
    icnt_next = (icnt == TIMEOUT) ? icnt : icnt + 1'b1;
  end

  // NOTE: every flop here uses non-blocking assignment so all stages sample the
  // pre-edge values; blocking would collapse the synchronizer chain into one flop.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      pcnt      <= '0;
      icnt      <= '0;
      stalled   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], slow_in};
      prev_q    <= slow_sync;
      rise_tick <= rise;
      fall_tick <= fall;
      pcnt      <= rise ? '0 : pcnt_inc;
      icnt      <= edge_seen ? '0 : icnt_next;
      stalled   <= stall_hit;
    end
  end

  // The first rise after reset or a stall only arms; a period needs two rises.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) state <= ARMED;
        end
        ARMED: begin
          if (rise) begin
            state        <= LOCKED;
            period       <= pcnt_inc;
            period_valid <= 1'b1;
          end else if (stall_hit) begin
            state        <= IDLE;
            period_valid <= 1'b0;
          end
        end
        LOCKED: begin
          if (rise) begin
            period <= pcnt_inc;
          end else if (stall_hit) begin
            state        <= IDLE;
            period_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          period_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/slowclk_edge_monitor.md
# slowclk_edge_monitor

Receiving-side companion to the slow clock divider. Accepts a slow, square-wave clock-like signal (divided clock or any other low-rate toggling input), synchronizes it into the `clk_in` domain, and emits single-cycle rise/fall ticks. It also measures the rising-edge period in `clk_in` cycles and flags a stall when the input stops toggling. Downstream lock logic (display blink, timeout counters) consumes the ticks as clock enables instead of clocking flops from a divided clock.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `slow_in`; legal values are 2 to 4.
- `CNT_W`, 26: width of the period and idle counters.
- `TIMEOUT`, 26'd50_000_000: number of `clk_in` cycles without any edge before `stalled` asserts; legal range is 1 to 2^CNT_W−1.

- `clk_in`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `slow_in`  in  1  slow toggling input; asynchronous to `clk_in`.
- `slow_sync`  out  1  synchronized copy of `slow_in`.
- `rise_tick`  out  1  one-cycle pulse per synchronized rising edge.
- `fall_tick`  out  1  one-cycle pulse per synchronized falling edge.
- `period`  out  CNT_W  `clk_in` cycles between the last two `rise_tick`s.
- `period_valid`  out  1  `period` holds a real measurement.
- `stalled`  out  1  no edge seen for `TIMEOUT` cycles.

## Operation
- Reset (`rst`=0) clears all flops. While in reset: `slow_sync`=0, `rise_tick`=0, `fall_tick`=0, `period`=0, `period_valid`=0, `stalled`=0. The state is IDLE and both counters are 0.
- Synchronizer: a chain of `SYNC_STAGES` flops. `slow_sync` is the last stage. A `prev` flop holds the previous `slow_sync`.
- Edge detect: rise = `slow_sync & ~prev`; fall = `~slow_sync & prev`. `rise_tick` and `fall_tick` are registered and never both high in the same cycle. The first cycle after reset release never produces a tick, because `prev` resets to 0 and the chain is 0.
- Period counter `pcnt`:
  - Increments every cycle and saturates at 2^CNT_W−1.
  - In the cycle a rise is detected, `pcnt` is set to 0.
  - In that same cycle, when the state is ARMED or LOCKED, `period` is loaded with `pcnt`+1, saturating at 2^CNT_W−1.
- Idle counter `icnt`:
  - Set to 0 on any detected edge (rise or fall).
  - Otherwise increments, saturating at `TIMEOUT`.
  - `stalled` = registered (`icnt` == `TIMEOUT`).
- State machine:
  - IDLE → ARMED on a rise. `period` is not loaded on this transition.
  - ARMED → LOCKED on a rise. `period` is loaded and `period_valid` is set to 1.
  - LOCKED → LOCKED on a rise. `period` is reloaded.
  - ARMED or LOCKED → IDLE when `stalled` asserts. `period_valid` clears to 0; `period` keeps its last value.
  - In IDLE, a rise in the same cycle as the stall condition takes priority: the edge wins, `icnt` clears, and `stalled` does not assert.
- Falling edges never change state and never affect `period`.
- When `stalled` is high, the next detected edge clears it. `stalled` falls in the cycle after that edge is detected, in the same cycle the tick is emitted.

## Timing
- Latency: a `slow_in` change captured at clock edge k appears on `slow_sync` after k+SYNC_STAGES−1. The corresponding tick is high for exactly one cycle after k+SYNC_STAGES.
- `period` and `period_valid` update in the same cycle as the `rise_tick` that produced them.
- Measurement rule: for `rise_tick` at cycles t1 and t2, `period` = t2−t1.
- Stall timing:
  - With a last edge tick at cycle t, `stalled` goes high at t+TIMEOUT+1.
  - After reset release at cycle r with no edges, `stalled` goes high at r+TIMEOUT+1.
- Reset is asserted asynchronously: outputs go to their reset values immediately and do not wait for a clock edge. Reset release must be synchronous to `clk_in`; this is the integrator's responsibility.
- Reset asserted mid-measurement discards everything. The first post-reset rise only arms the state machine.

## Test plan
- Reset values: assert `rst`=0 mid-run with `slow_in` high. All outputs must go to 0 immediately. After release, `slow_sync` must go to 1 after SYNC_STAGES clocks, followed by exactly one `rise_tick`.
- Steady period: `slow_in` toggles every 6 cycles (period 12). `rise_tick` and `fall_tick` must alternate 6 cycles apart. `period_valid` must be 0 after the first rise and 1 after the second, with `period`=12 from then on.
- Period change: switch `slow_in` from period 12 to period 20. The first `period` update after the switch must reflect the actual rise-to-rise spacing. All later updates must read 20.
- Stall and recovery: with `TIMEOUT`=30, hold `slow_in` constant after the last edge tick at t.
  - `stalled` must be 1 at t+31, with `period_valid`=0 and `period` unchanged.
  - The next rise must clear `stalled`, return the state to ARMED, and keep `period_valid`=0 until a second rise arrives.
- Saturation: with `CNT_W`=4 and `TIMEOUT`=15, use a rise spacing of 40 cycles plus a toggle that keeps `icnt` below `TIMEOUT`. `period` must read 15 (saturated) and must not wrap.
- Glitch: a 1-cycle `slow_in` pulse aligned to the sampling edge produces at most one rise and one fall tick, never two simultaneous ticks.
